// File: rtl/avalon_block_reader.sv
// avalon_block_reader: Avalon-MM read master that fetches a block of
// consecutive words and streams them out over valid/ready. Reads are only
// issued when a FIFO slot is reserved for the response, so the FIFO can
// never overflow regardless of slave read latency.
module avalon_block_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [DATA_W-1:0]     src_data,
  output logic                  src_valid,
  input  logic                  src_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  issue_cnt_reg, issue_cnt_next;
  logic [LEN_W-1:0]  consumed_reg, consumed_next;
  logic [CNT_W-1:0]  pending_reg, pending_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic              read_reg, read_next;
  logic              done_reg, done_next;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic             accept;
  logic             read_held;
  logic             active;
  logic             flush;
  logic             push;
  logic             pop;
  logic             start_ok;
  logic [CNT_W:0]   credit_used;

  assign accept    = read_reg & ~avm_waitrequest;
  assign read_held = read_reg & avm_waitrequest;
  assign active    = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
  assign flush     = active & abort;
  // Responses are kept only for a live block; an abort discards the word arriving with it.
  assign push      = avm_readdatavalid & active & ~abort;
  assign pop       = (count_reg != '0) & src_ready;
  assign start_ok  = (state_reg == S_IDLE) & start;
  // Slots committed after this edge: outstanding reads plus words already buffered.
  assign credit_used = {1'b0, pending_next} + {1'b0, count_next};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state decisions; completion looks at next-cycle counts so done follows the last pop.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start && (length != '0)) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort)                                           state_next = S_FLUSH;
        else if (accept && (issue_cnt_next == len_reg))      state_next = S_WAIT;
      end
      S_WAIT: begin
        if (abort) state_next = S_FLUSH;
        else if ((pending_next == '0) && (count_next == '0) && (consumed_next == len_reg))
          state_next = S_IDLE;
      end
      S_FLUSH: begin
        // A read still stalled by waitrequest must finish before the drain can end.
        if ((pending_next == '0) && !read_held) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Counter, address and FIFO pointer updates.
  always_comb begin
    addr_next      = addr_reg;
    len_next       = len_reg;
    issue_cnt_next = issue_cnt_reg;
    consumed_next  = consumed_reg;
    pending_next   = pending_reg + CNT_W'(accept) - CNT_W'(avm_readdatavalid);
    count_next     = count_reg + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_next    = wr_ptr_reg + PTR_W'(push);
    rd_ptr_next    = rd_ptr_reg + PTR_W'(pop);
    if (start_ok) begin
      addr_next      = base_addr;
      len_next       = length;
      issue_cnt_next = '0;
      consumed_next  = '0;
    end else begin
      if (accept) begin
        addr_next      = addr_reg + ADDR_W'(1);
        issue_cnt_next = issue_cnt_reg + LEN_W'(1);
      end
      if (pop && active) consumed_next = consumed_reg + LEN_W'(1);
    end
    if (flush) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
  end

  // Registered datapath and handshake state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg      <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      consumed_reg  <= '0;
      pending_reg   <= '0;
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      read_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      addr_reg      <= addr_next;
      len_reg       <= len_next;
      issue_cnt_reg <= issue_cnt_next;
      consumed_reg  <= consumed_next;
      pending_reg   <= pending_next;
      count_reg     <= count_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      read_reg      <= read_next;
      done_reg      <= done_next;
    end
  end

  // FIFO storage write port; no reset so it can map onto memory.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= avm_readdata;
  end

  // Output decode plus registered-output next values (read request and done pulse).
  always_comb begin
    busy           = (state_reg != S_IDLE);
    done           = done_reg;
    avm_read       = read_reg;
    avm_address    = addr_reg;
    avm_byteenable = '1;
    src_valid      = (count_reg != '0);
    src_data       = (count_reg != '0) ? fifo_mem[rd_ptr_reg] : '0;
    // A stalled read is never withdrawn; a new one needs work left and a free slot.
    read_next      = read_held |
                     ((state_next == S_ISSUE) && (issue_cnt_next < len_next) &&
                      (credit_used < {1'b0, DEPTH_C}));
    done_next      = (start_ok && (length == '0)) ||
                     ((state_reg == S_WAIT) && (state_next == S_IDLE));
  end

  // A push into a full FIFO with no pop would mean the credit accounting is broken.
  overflow_check: assert property (@(posedge clk) disable iff (!reset_n)
                                   !(push && !pop && (count_reg == DEPTH_C)));

endmodule

// File: tb/tb_avalon_block_reader.sv
// Directed testbench for avalon_block_reader with a latency-configurable
// slave model and a scoreboard of expected stream words.
module tb_avalon_block_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [12:0] base_addr;
  logic [13:0] length;
  logic        busy, done;
  logic [12:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;

  avalon_block_reader #(.ADDR_W(13), .DATA_W(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [12:0] a);
    return 32'hDEAD_0000 ^ {3'b000, a, 3'b000, a};
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          stall_idx = -1;
  int          stall_len = 0;
  int          stall_done = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          first_acc = 0;
  int          last_acc = 0;
  logic [12:0] exp_addr = '0;
  logic        held_prev = 1'b0;
  logic [12:0] held_addr = '0;

  // Slave model: returns data `lat` cycles after accept, stalls a chosen read.
  always @(posedge clk) begin
    #1;
    cyc++;
    avm_readdatavalid = 1'b0;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = resp_q[0].data;
      resp_q.delete(0);
    end
    avm_waitrequest = (stall_idx >= 0) && (acc_cnt == stall_idx) && (stall_done < stall_len);
  end

  // Monitor: sampled mid-cycle, checks handshakes and scoreboard order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (held_prev) begin
        check("hold_read", avm_read, 1);
        check("hold_addr", avm_address, held_addr);
      end
      held_prev = avm_read && avm_waitrequest;
      held_addr = avm_address;
      if (avm_read && avm_waitrequest) stall_done++;
      if (avm_read && !avm_waitrequest) begin
        check("rd_addr", avm_address, exp_addr);
        check("busy_on_rd", busy, 1);
        exp_q.push_back(word_of(exp_addr));
        resp_q.push_back('{due: cyc + lat, data: word_of(avm_address)});
        if (acc_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
        exp_addr = exp_addr + 13'd1;
        $display("cyc %0d: read accepted addr=0x%04h", cyc, avm_address);
      end
      if (src_valid && src_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        check("busy_on_pop", busy, 1);
        if (exp_q.size() != 0) begin
          check("pop_data", src_data, exp_q[0]);
          exp_q.delete(0);
        end
        $display("cyc %0d: word popped data=0x%08h", cyc, src_data);
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", busy, 0);
        $display("cyc %0d: done pulse", cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [12:0] b, input logic [13:0] l);
    base_addr  = b;
    length     = l;
    start      = 1'b1;
    exp_addr   = b;
    acc_cnt    = 0;
    done_cnt   = 0;
    stall_done = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0 || resp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, n < budget, 1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    src_ready = 1'b0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", avm_read, 0);
    check("rst_addr", avm_address, 0);
    check("rst_valid", src_valid, 0);
    check("rst_data", src_data, 0);
    check("byteenable", avm_byteenable, 4'hF);
    reset_n = 1'b1;
    tick();

    // Basic block
    src_ready = 1'b1; lat = 1;
    do_start(13'h0010, 14'd4);
    check("basic_busy", busy, 1);
    wait_idle("basic", 50);
    tick();
    check("basic_acc", acc_cnt, 4);
    check("basic_consec", last_acc - first_acc, 3);
    check("basic_done", done_cnt, 1);
    check("basic_idle", busy, 0);

    // Backpressure
    src_ready = 1'b0;
    do_start(13'h0100, 14'd20);
    repeat (30) tick();
    check("bp_acc8", acc_cnt, 8);
    check("bp_read_off", avm_read, 0);
    check("bp_valid", src_valid, 1);
    src_ready = 1'b1;
    wait_idle("bp", 200);
    tick();
    check("bp_acc20", acc_cnt, 20);
    check("bp_done", done_cnt, 1);

    // Waitrequest on the second read
    stall_idx = 1; stall_len = 3;
    do_start(13'h0200, 14'd6);
    wait_idle("wr", 100);
    tick();
    check("wr_acc", acc_cnt, 6);
    check("wr_stalls", stall_done, 3);
    check("wr_done", done_cnt, 1);
    stall_idx = -1;

    // Address wrap
    do_start(13'h1FFE, 14'd4);
    wait_idle("wrap", 50);
    tick();
    check("wrap_acc", acc_cnt, 4);
    check("wrap_addr_end", avm_address, 13'h0002);
    check("wrap_done", done_cnt, 1);

    // Zero length
    do_start(13'h0300, 14'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    tick();
    check("len0_done_end", done, 0);
    check("len0_busy2", busy, 0);
    check("len0_read", avm_read, 0);
    check("len0_acc", acc_cnt, 0);

    // Abort with reads in flight
    lat = 3; src_ready = 1'b0;
    do_start(13'h0400, 14'd16);
    n = 0;
    while (acc_cnt < 4 && n < 50) begin
      tick();
      n++;
    end
    check("abort_reach", acc_cnt, 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("abort_valid", src_valid, 0);
    check("abort_read", avm_read, 0);
    check("abort_flushing", busy, 1);
    src_ready = 1'b1;
    wait_idle("abort", 50);
    repeat (3) tick();
    check("abort_acc", acc_cnt, 5);
    check("abort_nodone", done_cnt, 0);
    check("abort_idle", busy, 0);
    check("abort_valid_end", src_valid, 0);

    // Clean block after abort
    lat = 2;
    do_start(13'h0500, 14'd6);
    wait_idle("post", 60);
    tick();
    check("post_acc", acc_cnt, 6);
    check("post_done", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
